cpu_run_ctrl: RTL and testbench

Run-control sequencer for the single-cycle MIPS core. It turns the board pause switch and step button into PC-enable gating, and decodes syscall service requests into a halt or an LED display update. It owns the performance counters: total cycles, conditional branches taken and unconditional jumps. It sits between the core's Controler/RegFile outputs and the PC register, and drives the PC register's reg_enable.

---
 rtl/cpu_ctrl_pkg.sv | 26 ++
 rtl/Counter.sv | 24 ++
 rtl/sync_edge.sv | 33 +++
 rtl/cpu_run_ctrl.sv | 176 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the run-control sequencer: FSM state
// encoding and default widths / halt service code.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'b00,
      PAUSED = 2'b01,
      STEP   = 2'b10,
      HALTED = 2'b11
   } run_state_t;

   localparam int unsigned DEF_CNT_W       = 32;
   localparam int unsigned DEF_LED_W       = 32;
   localparam int unsigned DEF_SYNC_STAGES = 2;
   localparam int unsigned DEF_HALT_CODE   = 10;

   // Syscall asks for a halt when $v0 holds the halt service code.
   function automatic logic is_halt_sc(
      input logic        sc,
      input logic [31:0] v0,
      input logic [31:0] code
   );
      return sc & (v0 == code);
   endfunction

endpackage

// File: rtl/Counter.sv
// Free-running enable-gated up counter, wraps modulo 2^W.
// Ports: clk, rst (async active-low), counter_enable -> o_count.
module Counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         counter_enable,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (counter_enable) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus a one-cycle
// rising-edge pulse on the synchronized level.
// Ports: clk, rst (async active-low), i_async -> o_level, o_pulse.
module sync_edge #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_level,
   output logic o_pulse
);

   // Fewer than two flops cannot resolve metastability; clamp.
   localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

   logic [N-1:0] r_sync;
   logic         r_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[N-2:0], i_async};
         r_prev <= r_sync[N-1];
      end
   end

   assign o_level = r_sync[N-1];
   assign o_pulse = r_sync[N-1] & ~r_prev;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the single-cycle MIPS core: pause/step
// gating of the PC write enable, syscall halt / LED display, and the
// cycle / taken-branch / jump performance counters.
// Ports: clk, rst (async active-low), pause, step, syscall,
//   syscall_v0, syscall_a0, branch_cond, branch_taken, jump ->
//   pc_enable (comb), halted, run_state, total_cycles,
//   condi_branch_num, uncondi_branch_num, led_data_in.
module cpu_run_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned LED_W       = DEF_LED_W,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned HALT_CODE   = DEF_HALT_CODE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pause,
   input  logic             step,
   input  logic             syscall,
   input  logic [31:0]      syscall_v0,
   input  logic [31:0]      syscall_a0,
   input  logic             branch_cond,
   input  logic             branch_taken,
   input  logic             jump,
   output logic             pc_enable,
   output logic             halted,
   output logic [1:0]       run_state,
   output logic [CNT_W-1:0] total_cycles,
   output logic [CNT_W-1:0] condi_branch_num,
   output logic [CNT_W-1:0] uncondi_branch_num,
   output logic [LED_W-1:0] led_data_in
);

   localparam logic [31:0] HALT_V0 = 32'(HALT_CODE);

   run_state_t       r_state;
   run_state_t       w_next;
   logic             r_halted;
   logic [LED_W-1:0] r_led;

   logic w_pause_s;
   logic w_pause_pulse;
   logic w_step_s;
   logic w_step_pulse;

   logic w_exec;
   logic w_halt_sc;
   logic w_commit;
   logic w_cond_en;
   logic w_jump_en;
   logic w_led_en;

   sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_sync_pause (
      .clk     (clk),
      .rst     (rst),
      .i_async (pause),
      .o_level (w_pause_s),
      .o_pulse (w_pause_pulse)
   );

   sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_sync_step (
      .clk     (clk),
      .rst     (rst),
      .i_async (step),
      .o_level (w_step_s),
      .o_pulse (w_step_pulse)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= RUN;
         r_halted <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_halted <= (w_next == HALTED);
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         RUN: begin
            if (w_exec & w_halt_sc) begin
               w_next = HALTED;
            end else if (w_pause_s) begin
               w_next = PAUSED;
            end else begin
               w_next = RUN;
            end
         end
         PAUSED: begin
            // Release wins over a coincident step press.
            if (!w_pause_s) begin
               w_next = RUN;
            end else if (w_step_pulse) begin
               w_next = STEP;
            end else begin
               w_next = PAUSED;
            end
         end
         STEP: begin
            // Always return through PAUSED; RUN follows if released.
            w_next = w_halt_sc ? HALTED : PAUSED;
         end
         HALTED: begin
            w_next = HALTED;
         end
         default: begin
            w_next = RUN;
         end
      endcase
   end

   // Output / enable logic
   always_comb begin
      w_halt_sc = is_halt_sc(syscall, syscall_v0, HALT_V0);
      w_exec    = ((r_state == RUN) & ~w_pause_s) | (r_state == STEP);
      // An executing halt syscall counts as a cycle but not a commit.
      w_commit  = w_exec & ~w_halt_sc;
      w_cond_en = w_commit & branch_cond & branch_taken;
      w_jump_en = w_commit & jump;
      w_led_en  = w_commit & syscall;
      pc_enable = w_commit & rst;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_led <= '0;
      end else if (w_led_en) begin
         r_led <= syscall_a0[LED_W-1:0];
      end
   end

   Counter #(
      .W (CNT_W)
   ) u_cnt_total (
      .clk            (clk),
      .rst            (rst),
      .counter_enable (w_exec),
      .o_count        (total_cycles)
   );

   Counter #(
      .W (CNT_W)
   ) u_cnt_cond (
      .clk            (clk),
      .rst            (rst),
      .counter_enable (w_cond_en),
      .o_count        (condi_branch_num)
   );

   Counter #(
      .W (CNT_W)
   ) u_cnt_jump (
      .clk            (clk),
      .rst            (rst),
      .counter_enable (w_jump_en),
      .o_count        (uncondi_branch_num)
   );

   assign halted      = r_halted;
   assign run_state   = r_state;
   assign led_data_in = r_led;

   // Pause edge pulse is not needed by the sequencer.
   logic w_unused;
   assign w_unused = w_pause_pulse;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: reference model plus
// directed scenarios with literal expectations.
module tb_cpu_run_ctrl;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pause = 1'b0;
   logic        step = 1'b0;
   logic        syscall = 1'b0;
   logic [31:0] v0 = '0;
   logic [31:0] a0 = '0;
   logic        bc = 1'b0;
   logic        bt = 1'b0;
   logic        jump = 1'b0;

   logic        pce;
   logic        halted;
   logic [1:0]  rs;
   logic [31:0] tot;
   logic [31:0] cb;
   logic [31:0] ub;
   logic [31:0] led;

   logic        s_pce;
   logic        s_halted;
   logic [1:0]  s_rs;
   logic [3:0]  s_tot;
   logic [3:0]  s_cb;
   logic [3:0]  s_ub;
   logic [31:0] s_led;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cpu_run_ctrl u_dut (
      .clk                (clk),
      .rst                (rst),
      .pause              (pause),
      .step               (step),
      .syscall            (syscall),
      .syscall_v0         (v0),
      .syscall_a0         (a0),
      .branch_cond        (bc),
      .branch_taken       (bt),
      .jump               (jump),
      .pc_enable          (pce),
      .halted             (halted),
      .run_state          (rs),
      .total_cycles       (tot),
      .condi_branch_num   (cb),
      .uncondi_branch_num (ub),
      .led_data_in        (led)
   );

   cpu_run_ctrl #(.CNT_W(4)) u_small (
      .clk                (clk),
      .rst                (rst),
      .pause              (pause),
      .step               (step),
      .syscall            (syscall),
      .syscall_v0         (v0),
      .syscall_a0         (a0),
      .branch_cond        (bc),
      .branch_taken       (bt),
      .jump               (jump),
      .pc_enable          (s_pce),
      .halted             (s_halted),
      .run_state          (s_rs),
      .total_cycles       (s_tot),
      .condi_branch_num   (s_cb),
      .uncondi_branch_num (s_ub),
      .led_data_in        (s_led)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   // Reference model: mode 0=run 1=paused 2=single step 3=halted
   int          m_mode;
   bit          ph [S];
   bit          sh [S+1];
   logic [31:0] m_tot;
   logic [31:0] m_cb;
   logic [31:0] m_ub;
   logic [31:0] m_led;
   bit          m_go;
   bit          m_hs;

   task automatic model_reset();
      m_mode = 0;
      m_tot = 0;
      m_cb = 0;
      m_ub = 0;
      m_led = 0;
      for (int i = 0; i < S; i++) ph[i] = 0;
      for (int i = 0; i <= S; i++) sh[i] = 0;
   endtask

   initial model_reset();

   always begin
      bit ps;
      bit sp;
      @(negedge clk);
      #4;
      ps = ph[S-1];
      sp = sh[S-1] && !sh[S];
      if (!rst) begin
         model_reset();
         m_go = 0;
         m_hs = 0;
      end else begin
         m_go = (m_mode == 0 && !ps) || m_mode == 2;
         m_hs = syscall && v0 == 32'd10;
      end
      chk("pc_enable", pce, rst && m_go && !m_hs);
      chk("s_pc_enable", s_pce, rst && m_go && !m_hs);
      @(posedge clk);
      if (rst) begin
         if (m_go) begin
            m_tot = m_tot + 1;
            if (!m_hs) begin
               if (bc && bt) m_cb = m_cb + 1;
               if (jump) m_ub = m_ub + 1;
               if (syscall) m_led = a0;
            end
         end
         case (m_mode)
            0: if (m_go && m_hs) m_mode = 3;
               else if (ps) m_mode = 1;
            1: if (!ps) m_mode = 0;
               else if (sp) m_mode = 2;
            2: m_mode = m_hs ? 3 : 1;
            default: m_mode = 3;
         endcase
         for (int i = S - 1; i > 0; i--) ph[i] = ph[i-1];
         ph[0] = pause;
         for (int i = S; i > 0; i--) sh[i] = sh[i-1];
         sh[0] = step;
      end
      #1;
      chk("run_state", rs, m_mode[1:0]);
      chk("halted", halted, m_mode == 3);
      chk("total", tot, m_tot);
      chk("condi", cb, m_cb);
      chk("uncondi", ub, m_ub);
      chk("led", led, m_led);
      chk("s_run_state", s_rs, m_mode[1:0]);
      chk("s_total", s_tot, m_tot[3:0]);
      chk("s_condi", s_cb, m_cb[3:0]);
      chk("s_uncondi", s_ub, m_ub[3:0]);
   end

   task automatic clr();
      syscall = 0;
      v0 = 0;
      a0 = 0;
      bc = 0;
      bt = 0;
      jump = 0;
   endtask

   initial begin
      int cnt;
      bit seen;
      repeat (3) @(negedge clk);
      rst = 1;
      // counting: 5 cycles
      @(negedge clk); bc = 1; bt = 1;
      @(negedge clk); bt = 0;
      @(negedge clk); bc = 0; jump = 1;
      @(negedge clk); jump = 0;
      @(negedge clk);
      chk("L_cnt_total", tot, 5);
      chk("L_cnt_condi", cb, 1);
      chk("L_cnt_uncondi", ub, 1);
      // reset mid-run
      rst = 0;
      #1;
      chk("L_rst_total", tot, 0);
      chk("L_rst_condi", cb, 0);
      chk("L_rst_pce", pce, 0);
      chk("L_rst_state", rs, 0);
      chk("L_rst_led", led, 0);
      repeat (2) @(negedge clk);
      rst = 1;
      #1;
      chk("L_rel_pce", pce, 1);
      // pause / step
      repeat (3) @(negedge clk);
      pause = 1;
      repeat (3) @(negedge clk);
      chk("L_pause_state", rs, 1);
      chk("L_pause_pce", pce, 0);
      chk("L_pause_total", tot, 5);
      repeat (4) @(negedge clk);
      chk("L_frozen_total", tot, 5);
      step = 1;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         #1;
         if (pce) cnt++;
      end
      chk("L_step_once", cnt, 1);
      chk("L_step_total", tot, 6);
      chk("L_step_state", rs, 1);
      step = 0;
      repeat (3) @(negedge clk);
      pause = 0;
      repeat (4) @(negedge clk);
      chk("L_resume_state", rs, 0);
      chk("L_resume_total", tot, 7);
      // display syscall
      syscall = 1; v0 = 1; a0 = 32'h0000_00AB;
      #1;
      chk("L_disp_pce", pce, 1);
      @(negedge clk);
      clr();
      chk("L_disp_led", led, 32'hAB);
      chk("L_disp_state", rs, 0);
      chk("L_disp_total", tot, 8);
      // wrap of the 4-bit instance
      rst = 0;
      @(negedge clk);
      rst = 1;
      repeat (16) @(negedge clk);
      chk("L_wrap_small", s_tot, 0);
      chk("L_wrap_big", tot, 16);
      // halt while single-stepping
      pause = 1;
      repeat (4) @(negedge clk);
      chk("L_hs_paused", rs, 1);
      step = 1;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (rs == 2'b10) seen = 1;
      end
      chk("L_hs_reach_step", seen, 1);
      syscall = 1; v0 = 10;
      #1;
      chk("L_hs_pce", pce, 0);
      @(negedge clk);
      clr();
      chk("L_hs_halted", halted, 1);
      chk("L_hs_state", rs, 3);
      chk("L_hs_total", tot, 19);
      pause = 0;
      step = 0;
      rst = 0;
      #1;
      chk("L_hs_rst_halted", halted, 0);
      chk("L_hs_rst_state", rs, 0);
      @(negedge clk);
      rst = 1;
      // halt from run
      repeat (2) @(negedge clk);
      syscall = 1; v0 = 10; a0 = 32'h55;
      #1;
      chk("L_halt_pce", pce, 0);
      @(negedge clk);
      clr();
      chk("L_halt_halted", halted, 1);
      chk("L_halt_state", rs, 3);
      chk("L_halt_total", tot, 3);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         pause = i[0];
         step = i[1];
         bc = 1;
         bt = 1;
         jump = i[2];
         syscall = 1;
         v0 = 1;
         a0 = 32'h77;
      end
      @(negedge clk);
      clr();
      pause = 0;
      step = 0;
      chk("L_absorb_total", tot, 3);
      chk("L_absorb_condi", cb, 0);
      chk("L_absorb_uncondi", ub, 0);
      chk("L_absorb_led", led, 0);
      chk("L_absorb_state", rs, 3);
      rst = 0;
      #1;
      chk("L_final_rst_state", rs, 0);
      @(negedge clk);
      rst = 1;
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
